// File: rtl/ball_rom_arbiter.sv
// Round-robin arbiter sharing one ball sprite ROM; maps (size, dx, dy) to a linear address. Optional macro BALL_ARB_PRIO0_EN: req[0] always wins.
// Latency: capture edge E -> rsp_valid after edge E+1; one lookup per cycle at full throughput.
// Backpressure: rsp_valid & !rsp_ready holds s2, holds s1 when valid, and suppresses ack.
module ball_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 5,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       req_size,
    input  logic [COORD_W*N_REQ-1:0] req_dx,
    input  logic [COORD_W*N_REQ-1:0] req_dy,
    output logic [N_REQ-1:0]         ack,
    output logic [18:0]              rom_addr,
    output logic [1:0]               rom_size,
    input  logic [3:0]               rom_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [3:0]               rsp_data,
    output logic                     rsp_oob
);

`ifdef BALL_ARB_PRIO0_EN
    localparam logic [ID_W-1:0] RR_RST = ID_W'(1);
`else
    localparam logic [ID_W-1:0] RR_RST = '0;
`endif

    logic [ID_W-1:0]    rr_ptr;
    logic               s1_valid;
    logic [18:0]        s1_addr;
    logic [1:0]         s1_size;
    logic [ID_W-1:0]    s1_id;
    logic               s1_oob;

    logic [1:0]         size_a [N_REQ];
    logic [COORD_W-1:0] dx_a   [N_REQ];
    logic [COORD_W-1:0] dy_a   [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign size_a[g] = req_size[2*g +: 2];
        assign dx_a[g]   = req_dx[COORD_W*g +: COORD_W];
        assign dy_a[g]   = req_dy[COORD_W*g +: COORD_W];
    end

    // Wrap base+k back into the range lo..N_REQ-1.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k, input int lo);
        int v;
        v = int'(base) + k;
        if (v >= N_REQ) v = v - N_REQ + lo;
        return ID_W'(v);
    endfunction

    logic            gnt_any;
    logic [ID_W-1:0] gnt_id;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
`ifdef BALL_ARB_PRIO0_EN
        if (req[0]) gnt_any = 1'b1;
        for (int k = 0; k < N_REQ-1; k++) begin
            if (!gnt_any && req[rr_idx(rr_ptr, k, 1)]) begin
                gnt_any = 1'b1;
                gnt_id  = rr_idx(rr_ptr, k, 1);
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && req[rr_idx(rr_ptr, k, 0)]) begin
                gnt_any = 1'b1;
                gnt_id  = rr_idx(rr_ptr, k, 0);
            end
        end
`endif
    end

    logic [ID_W-1:0] next_rr;

    always_comb begin
`ifdef BALL_ARB_PRIO0_EN
        if (gnt_id == '0)                       next_rr = rr_ptr;
        else if (gnt_id == ID_W'(N_REQ-1))      next_rr = ID_W'(1);
        else                                    next_rr = gnt_id + ID_W'(1);
`else
        if (gnt_id == ID_W'(N_REQ-1))           next_rr = '0;
        else                                    next_rr = gnt_id + ID_W'(1);
`endif
    end

    logic [1:0]         sel_size;
    logic [COORD_W-1:0] sel_dx, sel_dy;
    logic [4:0]         diam;
    logic               lk_oob;
    logic [18:0]        lk_addr;

    assign sel_size = size_a[gnt_id];
    assign sel_dx   = dx_a[gnt_id];
    assign sel_dy   = dy_a[gnt_id];

    always_comb begin
        case (sel_size)
            2'd0:    diam = 5'd10;
            2'd1:    diam = 5'd20;
            default: diam = 5'd30;
        endcase
    end

    assign lk_oob  = (int'(sel_dx) >= int'(diam)) || (int'(sel_dy) >= int'(diam));
    assign lk_addr = lk_oob ? 19'd0 : 19'(sel_dy) * 19'(diam) + 19'(sel_dx);

    logic s2_free, s1_adv, s1_load;

    assign s2_free = !rsp_valid || rsp_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign s1_load = Reset_n && gnt_any && (!s1_valid || s1_adv);

    always_comb begin
        ack = '0;
        if (s1_load) ack[gnt_id] = 1'b1;
    end

    assign rom_addr = s1_addr;
    assign rom_size = s1_size;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr   <= RR_RST;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_size  <= '0;
            s1_id    <= '0;
            s1_oob   <= 1'b0;
        end else if (s1_load) begin
            rr_ptr   <= next_rr;
            s1_valid <= 1'b1;
            s1_addr  <= lk_addr;
            s1_size  <= (sel_size == 2'd3) ? 2'd2 : sel_size;
            s1_id    <= gnt_id;
            s1_oob   <= lk_oob;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_oob   <= 1'b0;
        end else if (s1_adv) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_data  <= s1_oob ? 4'd0 : rom_data;
            rsp_oob   <= s1_oob;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
